// File: rtl/skinny_sbox8_hpc2_1_pipelined_layer.sv
// ---------------------------------------------------------------------------
// skinny_sbox8_hpc2_1_pipelined_layer
// Masked (2 shares, HPC2 order 1) SKINNY-128 8-bit S-box layer, LANES S-boxes
// in parallel, fully pipelined (8 stages, one slice per cycle) with
// valid/ready flow control.
//
// Each lane is the 8-gadget NOR-XOR network f = ((~x) & (~y)) ^ z:
//   depth 1: b764 (a0), b320 (a1)
//   depth 2: b216 (a2), b015 (a3)
//   depth 3: b131 (a4), b237 (a5)
//   depth 4: b303 (a6), b422 (a7)
// where bXYZ uses x = bit/a X, y = bit/a Y, z = bit Z.
// Output bits: a0->6, a1->5, a2->2, a3->7, a4->3, a5->1, a6->4, a7->0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready = advance, combinational)
//   si0, si1             input shares, lane l at [8l+7:8l]
//   r                    fresh randomness, lane l gadget g at bit 8l+g
//   out_valid/out_ready  output handshake
//   bo0, bo1             output shares, bo0^bo1 = S(si0^si1) per lane
//   occ                  number of valid stages (only with SBOX8_HPC2_OCC_CNT_EN)
//
// Optional feature macro: SBOX8_HPC2_OCC_CNT_EN adds the occupancy counter.
// ---------------------------------------------------------------------------

// One HPC2 order-1 NOR-XOR gadget: c = ((~x) & (~y)) ^ z, two register levels.
module sbox8_hpc2_nor_gadget (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic x0,
   input  logic x1,
   input  logic y0,
   input  logic y1,
   input  logic z0,
   input  logic z1,
   input  logic r,
   output logic c0,
   output logic c1
);
   // Complementing a shared value only needs one share inverted.
   logic xa0_s, xa1_s, ya0_s, ya1_s;
   assign xa0_s = ~x0;
   assign xa1_s = x1;
   assign ya0_s = ~y0;
   assign ya1_s = y1;

   (* equivalent_register_removal = "no" *) logic pp0_r, pp1_r;
   (* equivalent_register_removal = "no" *) logic ur0_r, ur1_r;
   (* equivalent_register_removal = "no" *) logic nr0_r, nr1_r;
   (* equivalent_register_removal = "no" *) logic xr0_r, xr1_r;
   (* equivalent_register_removal = "no" *) logic zr0_r, zr1_r;

   // Partial-product level: the only place r is consumed; cross share y is masked by r before registering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pp0_r <= 1'b0; pp1_r <= 1'b0;
         ur0_r <= 1'b0; ur1_r <= 1'b0;
         nr0_r <= 1'b0; nr1_r <= 1'b0;
         xr0_r <= 1'b0; xr1_r <= 1'b0;
         zr0_r <= 1'b0; zr1_r <= 1'b0;
      end else if (en) begin
         pp0_r <= xa0_s & ya0_s;
         pp1_r <= xa1_s & ya1_s;
         ur0_r <= ya1_s ^ r;
         ur1_r <= ya0_s ^ r;
         nr0_r <= ~xa0_s & r;
         nr1_r <= ~xa1_s & r;
         xr0_r <= xa0_s;
         xr1_r <= xa1_s;
         zr0_r <= z0;
         zr1_r <= z1;
      end
   end

   // XOR-with-z level: r terms cancel across the two shares, leaving x&y ^ z.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0 <= 1'b0;
         c1 <= 1'b0;
      end else if (en) begin
         c0 <= pp0_r ^ nr0_r ^ (xr0_r & ur0_r) ^ zr0_r;
         c1 <= pp1_r ^ nr1_r ^ (xr1_r & ur1_r) ^ zr1_r;
      end
   end
endmodule

// Two-stage share-separated delay line, aligned with one gadget's latency.
module sbox8_hpc2_dly2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   output logic [W-1:0] q0,
   output logic [W-1:0] q1
);
   (* equivalent_register_removal = "no" *) logic [W-1:0] s0_r, s1_r;

   // Shift both shares through their own registers; shares never meet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_r <= '0;
         s1_r <= '0;
         q0   <= '0;
         q1   <= '0;
      end else if (en) begin
         s0_r <= d0;
         s1_r <= d1;
         q0   <= s0_r;
         q1   <= s1_r;
      end
   end
endmodule

module skinny_sbox8_hpc2_1_pipelined_layer #(
   parameter  int LANES = 16,
   localparam int RW    = 8*LANES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [8*LANES-1:0] si0,
   input  logic [8*LANES-1:0] si1,
   input  logic [RW-1:0]    r,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [8*LANES-1:0] bo0,
   output logic [8*LANES-1:0] bo1
`ifdef SBOX8_HPC2_OCC_CNT_EN
   ,
   output logic [3:0]       occ
`endif
);
   logic       adv_s;
   logic [8:1] v_r;

   assign adv_s     = ~v_r[8] | out_ready;
   assign in_ready  = adv_s;
   assign out_valid = v_r[8];

   // Valid bit per stage; bubbles shift along with the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_r <= 8'h00;
      end else if (adv_s) begin
         v_r <= {v_r[7:1], in_valid};
      end
   end

`ifdef SBOX8_HPC2_OCC_CNT_EN
   logic [3:0] occ_r;
   logic       acc_s, drn_s;
   assign acc_s = in_valid & adv_s;
   assign drn_s = v_r[8] & out_ready;
   assign occ   = occ_r;

   // Occupancy: up on accept-only, down on drain-only, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r <= 4'd0;
      end else begin
         case ({acc_s, drn_s})
            2'b10:   occ_r <= occ_r + 4'd1;
            2'b01:   occ_r <= occ_r - 4'd1;
            default: occ_r <= occ_r;
         endcase
      end
   end
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] x0_s, x1_s;
      logic [7:0] ga0_s, ga1_s;   // gadget outputs a0..a7, per share
      logic [5:0] ca0_s, ca1_s;   // stage 2: {x6,x5,x2,x1,x7,x3}
      logic [3:0] cb0_s, cb1_s;   // stage 4: {x1,x7,x3,x2}
      logic [1:0] cc0_s, cc1_s;   // stage 6: {x3,x2}
      logic [1:0] cd0_s, cd1_s;   // stage 4: {a1,a0}
      logic [3:0] ce0_s, ce1_s;   // stage 6: {a3,a2,a1,a0}
      logic [5:0] cf0_s, cf1_s;   // stage 8: {a5,a4,a3,a2,a1,a0}

      assign x0_s = si0[8*l +: 8];
      assign x1_s = si1[8*l +: 8];

      sbox8_hpc2_dly2 #(.W(6)) u_ca (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .d0({x0_s[6], x0_s[5], x0_s[2], x0_s[1], x0_s[7], x0_s[3]}),
         .d1({x1_s[6], x1_s[5], x1_s[2], x1_s[1], x1_s[7], x1_s[3]}),
         .q0(ca0_s), .q1(ca1_s));
      sbox8_hpc2_dly2 #(.W(4)) u_cb (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .d0({ca0_s[2], ca0_s[1], ca0_s[0], ca0_s[3]}),
         .d1({ca1_s[2], ca1_s[1], ca1_s[0], ca1_s[3]}),
         .q0(cb0_s), .q1(cb1_s));
      sbox8_hpc2_dly2 #(.W(2)) u_cc (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .d0(cb0_s[1:0]), .d1(cb1_s[1:0]), .q0(cc0_s), .q1(cc1_s));
      sbox8_hpc2_dly2 #(.W(2)) u_cd (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .d0(ga0_s[1:0]), .d1(ga1_s[1:0]), .q0(cd0_s), .q1(cd1_s));
      sbox8_hpc2_dly2 #(.W(4)) u_ce (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .d0({ga0_s[3:2], cd0_s}), .d1({ga1_s[3:2], cd1_s}), .q0(ce0_s), .q1(ce1_s));
      sbox8_hpc2_dly2 #(.W(6)) u_cf (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .d0({ga0_s[5:4], ce0_s}), .d1({ga1_s[5:4], ce1_s}), .q0(cf0_s), .q1(cf1_s));

      // depth 1 (stage 0 -> 2)
      sbox8_hpc2_nor_gadget u_b764 (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .x0(x0_s[7]), .x1(x1_s[7]), .y0(x0_s[6]), .y1(x1_s[6]), .z0(x0_s[4]), .z1(x1_s[4]),
         .r(r[8*l+0]), .c0(ga0_s[0]), .c1(ga1_s[0]));
      sbox8_hpc2_nor_gadget u_b320 (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .x0(x0_s[3]), .x1(x1_s[3]), .y0(x0_s[2]), .y1(x1_s[2]), .z0(x0_s[0]), .z1(x1_s[0]),
         .r(r[8*l+1]), .c0(ga0_s[1]), .c1(ga1_s[1]));
      // depth 2 (stage 2 -> 4)
      sbox8_hpc2_nor_gadget u_b216 (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .x0(ca0_s[3]), .x1(ca1_s[3]), .y0(ca0_s[2]), .y1(ca1_s[2]), .z0(ca0_s[5]), .z1(ca1_s[5]),
         .r(r[8*l+2]), .c0(ga0_s[2]), .c1(ga1_s[2]));
      sbox8_hpc2_nor_gadget u_b015 (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .x0(ga0_s[0]), .x1(ga1_s[0]), .y0(ga0_s[1]), .y1(ga1_s[1]), .z0(ca0_s[4]), .z1(ca1_s[4]),
         .r(r[8*l+3]), .c0(ga0_s[3]), .c1(ga1_s[3]));
      // depth 3 (stage 4 -> 6)
      sbox8_hpc2_nor_gadget u_b131 (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .x0(cd0_s[1]), .x1(cd1_s[1]), .y0(cb0_s[1]), .y1(cb1_s[1]), .z0(cb0_s[3]), .z1(cb1_s[3]),
         .r(r[8*l+4]), .c0(ga0_s[4]), .c1(ga1_s[4]));
      sbox8_hpc2_nor_gadget u_b237 (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .x0(ga0_s[2]), .x1(ga1_s[2]), .y0(ga0_s[3]), .y1(ga1_s[3]), .z0(cb0_s[2]), .z1(cb1_s[2]),
         .r(r[8*l+5]), .c0(ga0_s[5]), .c1(ga1_s[5]));
      // depth 4 (stage 6 -> 8)
      sbox8_hpc2_nor_gadget u_b303 (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .x0(ce0_s[3]), .x1(ce1_s[3]), .y0(ce0_s[0]), .y1(ce1_s[0]), .z0(cc0_s[1]), .z1(cc1_s[1]),
         .r(r[8*l+6]), .c0(ga0_s[6]), .c1(ga1_s[6]));
      sbox8_hpc2_nor_gadget u_b422 (.clk(clk), .rst_n(rst_n), .en(adv_s),
         .x0(ga0_s[4]), .x1(ga1_s[4]), .y0(ga0_s[5]), .y1(ga1_s[5]), .z0(cc0_s[0]), .z1(cc1_s[0]),
         .r(r[8*l+7]), .c0(ga0_s[7]), .c1(ga1_s[7]));

      // Final bit placement is pure wiring of stage-8 registers.
      assign bo0[8*l +: 8] = {cf0_s[3], cf0_s[0], cf0_s[1], ga0_s[6],
                              cf0_s[4], cf0_s[2], cf0_s[5], ga0_s[7]};
      assign bo1[8*l +: 8] = {cf1_s[3], cf1_s[0], cf1_s[1], ga1_s[6],
                              cf1_s[4], cf1_s[2], cf1_s[5], ga1_s[7]};
   end
endmodule

// File: tb/tb_skinny_sbox8_hpc2_1_pipelined_layer.sv
// Directed bench for skinny_sbox8_hpc2_1_pipelined_layer (LANES = 16).
module tb_skinny_sbox8_hpc2_1_pipelined_layer;
   localparam int W = 128;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] si0 = '0;
   logic [W-1:0] si1 = '0;
   logic [W-1:0] r = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] bo0, bo1;
`ifdef SBOX8_HPC2_OCC_CNT_EN
   logic [3:0]   occ;
`endif

   int n_vec = 0;
   int n_err = 0;

   // reference pipeline: valid bits and expected unmasked outputs per stage
   logic [8:1]   mv;
   logic [W-1:0] md [1:8];

   always #5 clk = ~clk;

   skinny_sbox8_hpc2_1_pipelined_layer #(.LANES(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .si0(si0), .si1(si1), .r(r), .out_valid(out_valid), .out_ready(out_ready),
      .bo0(bo0), .bo1(bo1)
`ifdef SBOX8_HPC2_OCC_CNT_EN
      , .occ(occ)
`endif
   );

   // SKINNY-128 S-box from its definition: 4 NOR-XOR rounds, bit permutation, final bit1/bit2 swap.
   function automatic logic [7:0] sk_sbox(input logic [7:0] xi);
      logic [7:0] x, y;
      x = xi;
      for (int i = 0; i < 4; i++) begin
         x[4] = x[4] ^ ~(x[7] | x[6]);
         x[0] = x[0] ^ ~(x[3] | x[2]);
         if (i < 3) y = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
         else       y = {x[7], x[6], x[5], x[4], x[3], x[1], x[2], x[0]};
         x = y;
      end
      return x;
   endfunction

   function automatic logic [W-1:0] sbox_vec(input logic [W-1:0] x);
      logic [W-1:0] y;
      for (int l = 0; l < 16; l++) y[8*l +: 8] = sk_sbox(x[8*l +: 8]);
      return y;
   endfunction

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs, compare against the reference pipeline, advance it, clock.
   task automatic step(input logic iv, input logic [W-1:0] s0, input logic [W-1:0] s1,
                       input logic [W-1:0] rr, input logic ordy);
      logic m_adv;
      in_valid = iv; si0 = s0; si1 = s1; r = rr; out_ready = ordy;
      #1;
      m_adv = !mv[8] || ordy;
      check("out_valid", out_valid, mv[8]);
      check("in_ready", in_ready, m_adv);
      if (mv[8]) check("data", bo0 ^ bo1, md[8]);
`ifdef SBOX8_HPC2_OCC_CNT_EN
      check("occ", occ, 4'($countones(mv)));
`endif
      if (m_adv) begin
         for (int k = 8; k > 1; k--) begin
            mv[k] = mv[k-1];
            md[k] = md[k-1];
         end
         mv[1] = iv;
         md[1] = sbox_vec(s0 ^ s1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic iv, input logic [W-1:0] x, input logic ordy);
      logic [W-1:0] m;
      m = rnd128();
      step(iv, x ^ m, m, rnd128(), ordy);
   endtask

   initial begin
      logic [W-1:0] t0, t1, tmp, h0, h1, x;
      logic [4:0]   pat;
      mv = 8'h00;
      for (int k = 1; k <= 8; k++) md[k] = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_bo0", bo0, '0);
      check("rst_bo1", bo1, '0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      // single slice: lanes 0..3 carry x = 00, 01, 02, FF with hand-picked shares
      t0 = rnd128(); t1 = rnd128();
      t0[31:0] = 32'hF05A3CA5;
      t1[31:0] = 32'h0F583DA5;
      step(1'b1, t0, t1, rnd128(), 1'b1);
      for (int i = 0; i < 7; i++) feed(1'b0, '0, 1'b1);
      tmp = bo0 ^ bo1;
      check("t1_valid_at_8", out_valid, 1'b1);
      check("t1_sbox", tmp[31:0], 32'hFF6A4C65);
      for (int i = 0; i < 2; i++) feed(1'b0, '0, 1'b1);

      // extreme shares and randomness: result all ones
      step(1'b1, {W{1'b1}}, '0, '0, 1'b1);
      step(1'b1, {W{1'b1}}, '0, {W{1'b1}}, 1'b1);
      step(1'b1, '0, {W{1'b1}}, '0, 1'b1);
      step(1'b1, '0, {W{1'b1}}, {W{1'b1}}, 1'b1);
      for (int i = 0; i < 4; i++) feed(1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("t6_ff", bo0 ^ bo1, {W{1'b1}});
         feed(1'b0, '0, 1'b1);
      end
      for (int i = 0; i < 2; i++) feed(1'b0, '0, 1'b1);

      // valid pattern 1,0,1,1,0 reappears eight cycles later
      pat = 5'b01101;
      for (int i = 0; i < 5; i++) feed(pat[i], rnd128(), 1'b1);
      for (int i = 0; i < 3; i++) feed(1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("t4_pattern", out_valid, pat[i]);
         feed(1'b0, '0, 1'b1);
      end
      for (int i = 0; i < 2; i++) feed(1'b0, '0, 1'b1);

      // full sweep: every byte value through every lane, back to back
      for (int i = 0; i < 256; i++) begin
         for (int l = 0; l < 16; l++) x[8*l +: 8] = 8'(i + 17*l);
         feed(1'b1, x, 1'b1);
      end
      for (int i = 0; i < 9; i++) feed(1'b0, '0, 1'b1);

      // back-pressure with full pipe, then simultaneous accept and drain
      for (int i = 0; i < 8; i++) feed(1'b1, rnd128(), 1'b1);
      h0 = bo0; h1 = bo1;
      for (int i = 0; i < 5; i++) begin
         feed(1'b1, rnd128(), 1'b0);
         check("t3_hold_bo0", bo0, h0);
         check("t3_hold_bo1", bo1, h1);
      end
      for (int i = 0; i < 3; i++) feed(1'b1, rnd128(), 1'b1);
      for (int i = 0; i < 12; i++) feed(1'b0, '0, 1'b1);

      // reset with slices in flight and an output showing
      for (int i = 0; i < 4; i++) feed(1'b1, rnd128(), 1'b1);
      for (int i = 0; i < 4; i++) feed(1'b0, '0, 1'b1);
      check("t5_pre_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", out_valid, 1'b0);
      check("t5_rst_bo0", bo0, '0);
      check("t5_rst_bo1", bo1, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mv = 8'h00;
      for (int k = 1; k <= 8; k++) md[k] = '0;
      feed(1'b1, rnd128(), 1'b1);
      for (int i = 0; i < 10; i++) feed(1'b0, '0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
